// File: rtl/button_event.sv
// Button gesture decoder: press/release edges plus click, double-click and long-press
// events from a debounced level, timed by one shared saturating interval counter.
module button_event #(
  parameter int unsigned LONG_CYCLES   = 8000000,
  parameter int unsigned DCLICK_CYCLES = 4000000,
  parameter int unsigned CNT_W         = 24
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_level,
  input  logic en,
  output logic held,
  output logic press_pulse,
  output logic release_pulse,
  output logic click_pulse,
  output logic dclick_pulse,
  output logic long_pulse
);

  typedef enum logic [2:0] {IDLE, PRESS1, LONG, WAIT2, PRESS2} state_t;

  localparam logic [CNT_W-1:0] LONG_TC   = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] DCLICK_TC = CNT_W'(DCLICK_CYCLES - 1);

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt;
  logic             lvl_q;
  logic             rise, fall;
  logic             click_nx, dclick_nx, long_nx;

  assign rise = btn_level & ~lvl_q;
  assign fall = ~btn_level & lvl_q;
  assign held = lvl_q;

  always_comb begin
    state_nx  = state;
    click_nx  = 1'b0;
    dclick_nx = 1'b0;
    long_nx   = 1'b0;
    if (!en) begin
      state_nx = IDLE;
    end else begin
      case (state)
        IDLE:   if (rise) state_nx = PRESS1;
        PRESS1: begin
          // Terminal count wins over release; a simultaneous release ends the gesture.
          if (cnt == LONG_TC) begin
            long_nx  = 1'b1;
            state_nx = fall ? IDLE : LONG;
          end else if (fall) begin
            state_nx = WAIT2;
          end
        end
        LONG:   if (fall) state_nx = IDLE;
        WAIT2: begin
          // Timeout wins over a new press; that press then starts a fresh gesture.
          if (cnt == DCLICK_TC) begin
            click_nx = 1'b1;
            state_nx = rise ? PRESS1 : IDLE;
          end else if (rise) begin
            state_nx = PRESS2;
          end
        end
        PRESS2: begin
          if (fall) begin
            dclick_nx = 1'b1;
            state_nx  = IDLE;
          end
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lvl_q         <= 1'b0;
      state         <= IDLE;
      cnt           <= '0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      click_pulse   <= 1'b0;
      dclick_pulse  <= 1'b0;
      long_pulse    <= 1'b0;
    end else begin
      lvl_q <= btn_level;
      state <= state_nx;
      if (!en || state_nx != state) begin
        cnt <= '0;
      end else if (cnt != '1) begin
        cnt <= cnt + CNT_W'(1);
      end
      press_pulse   <= en & rise;
      release_pulse <= en & fall;
      click_pulse   <= click_nx;
      dclick_pulse  <= dclick_nx;
      long_pulse    <= long_nx;
    end
  end

endmodule

// File: doc/button_event.md
BUTTON_EVENT -- requirements
Module: button_event

Interface
REQ-001 Parameter LONG_CYCLES, default 8000000, held-press threshold in clk cycles (0.5 s at 16 MHz); legal range 2..2^CNT_W-1.
REQ-002 Parameter DCLICK_CYCLES, default 4000000, max release gap for a double click in clk cycles (0.25 s at 16 MHz); legal range 2..2^CNT_W-1.
REQ-003 Parameter CNT_W, default 24, width of the shared interval counter.
REQ-004 clk  input  1  system clock, 16 MHz, all logic on posedge.
REQ-005 rst_n  input  1  reset, asynchronous and active-low.
REQ-006 btn_level  input  1  debounced button level, synchronous to clk, 1 = pressed.
REQ-007 en  input  1  synchronous enable; 0 forces the FSM to IDLE and suppresses all event pulses.
REQ-008 held  output  1  registered copy of btn_level (lvl_q).
REQ-009 press_pulse  output  1  one-cycle pulse on each rising edge of btn_level.
REQ-010 release_pulse  output  1  one-cycle pulse on each falling edge of btn_level.
REQ-011 click_pulse  output  1  one-cycle pulse for a completed single short click.
REQ-012 dclick_pulse  output  1  one-cycle pulse for a completed double click.
REQ-013 long_pulse  output  1  one-cycle pulse when a first press reaches LONG_CYCLES.

Function
REQ-014 rise = btn_level & ~lvl_q and fall = ~btn_level & lvl_q, both evaluated before the edge that updates lvl_q.
REQ-015 All outputs are registered; each pulse is high for exactly one cycle, starting at the edge that samples the causing condition (1-cycle latency from btn_level).
REQ-016 press_pulse and release_pulse follow rise and fall when en=1, regardless of FSM state.
REQ-017 FSM states: IDLE, PRESS1, LONG, WAIT2, PRESS2; the counter clears on every state change and otherwise increments, saturating at all-ones.
REQ-018 IDLE: rise -> PRESS1.
REQ-019 PRESS1: counter == LONG_CYCLES-1 -> long_pulse, then LONG; otherwise fall -> WAIT2.
REQ-020 PRESS1, terminal count and fall in the same cycle: long_pulse and release_pulse both assert, next state IDLE.
REQ-021 LONG: fall -> IDLE; no click or dclick is ever produced from LONG.
REQ-022 WAIT2: counter == DCLICK_CYCLES-1 -> click_pulse, then IDLE; otherwise rise -> PRESS2.
REQ-023 WAIT2, timeout and rise in the same cycle: click_pulse asserts, next state PRESS1 (the rise counts as a new first press).
REQ-024 PRESS2: fall -> dclick_pulse, then IDLE; there is no long detection in PRESS2, and its counter only saturates.
REQ-025 At most one of click_pulse, dclick_pulse and long_pulse is high in any cycle.
REQ-026 en=0: the FSM goes to IDLE and the counter clears on the next edge; all five pulses are 0; lvl_q and held keep tracking btn_level.
REQ-027 en 0->1 while btn_level=1: no press_pulse is generated, and the FSM waits in IDLE for the next rise.

Reset
REQ-028 rst_n=0 asynchronously sets lvl_q=0, FSM=IDLE, counter=0 and all outputs to 0.
REQ-029 Reset asserted mid-gesture abandons the gesture with no pulse.
REQ-030 After rst_n deasserts with btn_level=1, the first edge yields press_pulse=1 and FSM=PRESS1.

Verification (bench uses LONG_CYCLES=20, DCLICK_CYCLES=10, en=1)
REQ-031 btn_level high for 5 cycles, then low for 12 cycles -> press_pulse at cycle 1, release_pulse at cycle 6, click_pulse exactly once, 10 cycles after release; no dclick_pulse or long_pulse.
REQ-032 High 5, low 4, high 3, low -> two press_pulse and two release_pulse, dclick_pulse on the cycle after the second fall, no click_pulse.
REQ-033 High 30 cycles -> long_pulse on the 20th cycle in PRESS1; after release, release_pulse only, with no click_pulse or dclick_pulse.
REQ-034 High 5, low exactly 10 with the rise coinciding with the WAIT2 timeout -> click_pulse and press_pulse in the same cycle; FSM=PRESS1, and a later 5-cycle press produces a second click_pulse.
REQ-035 Scenario REQ-032 with rst_n pulsed low during WAIT2 -> all outputs 0 immediately, no dclick_pulse or click_pulse, FSM=IDLE.
REQ-036 en=0 throughout a press/release -> held tracks btn_level and all five pulses stay 0.
